// File: rtl/id_stage_sb.sv
// id_stage_sb: decode stage between IF and EX with a per-register pending-write
// counter scoreboard, writeback-valid handshake, flush release and sticky error flag.
// Optional feature macro: ID_WB_FWD_EN (forward writeback data into the source operands).
module id_stage_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    halt_i,
  output logic [$clog2(NREG)-1:0] rs1a_o,
  output logic [$clog2(NREG)-1:0] rs2a_o,
  input  logic [XLEN-1:0]         rs1d_i,
  input  logic [XLEN-1:0]         rs2d_i,
  input  logic                    valid_i,
  input  logic [XLEN-1:0]         instr_i,
  input  logic [XLEN-1:0]         pc_i,
  output logic                    ack_o,
  input  logic                    ack_i,
  output logic                    valid_o,
  output logic [XLEN-1:0]         instr_o,
  output logic [XLEN-1:0]         pc_o,
  output logic [XLEN-1:0]         rs1_o,
  output logic [XLEN-1:0]         rs2_o,
  output logic [XLEN-1:0]         imm_o,
  output logic                    illegal_o,
  input  logic                    wb_valid_i,
  input  logic [$clog2(NREG)-1:0] wb_rd_i,
`ifdef ID_WB_FWD_EN
  input  logic [XLEN-1:0]         wb_data_i,
`endif
  output logic                    sb_empty_o,
  output logic                    sb_err_o
);

  localparam int unsigned AW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic            use_rd, use_rs1, use_rs2, bad_enc, invalid_c;
  logic [XLEN-1:0] imm_c;
  logic [AW-1:0]   rd_idx_c;
  logic            rd_wr_c;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sb_err_d, sb_empty_d;
  logic [CNT_W:0]   avail, dec;

  logic            out_wr_q;
  logic [AW-1:0]   out_rd_q;

  logic            fwd1_c, fwd2_c, rs1_rdy_c, rs2_rdy_c, rd_ok_c, issue_c, fl_dec_c;
  logic [XLEN-1:0] rs1_data_c, rs2_data_c;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign rd_f  = instr_i[11:7];
  assign rs1_f = instr_i[19:15];
  assign rs2_f = instr_i[24:20];

  // RV32I decoder: register usage, immediate and encoding legality
  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    bad_enc = 1'b0;
    imm_c   = '0;
    case (opc)
      7'b0110111, 7'b0010111: begin
        use_rd = 1'b1;
        imm_c  = XLEN'($signed({instr_i[31:12], 12'b0}));
      end
      7'b1101111: begin
        use_rd = 1'b1;
        imm_c  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
      end
      7'b1100111: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        bad_enc = (f3 != 3'd0);
        imm_c   = XLEN'($signed(instr_i[31:20]));
      end
      7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_enc = (f3 == 3'd2) || (f3 == 3'd3);
        imm_c   = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
      end
      7'b0000011: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        bad_enc = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        imm_c   = XLEN'($signed(instr_i[31:20]));
      end
      7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_enc = (f3 > 3'd2);
        imm_c   = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      end
      7'b0010011: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        if (f3 == 3'd1)      bad_enc = (f7 != 7'h00);
        else if (f3 == 3'd5) bad_enc = (f7 != 7'h00) && (f7 != 7'h20);
        imm_c   = XLEN'($signed(instr_i[31:20]));
      end
      7'b0110011: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_enc = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      7'b0001111, 7'b1110011: ;
      default: bad_enc = 1'b1;
    endcase
    if (use_rd  && (32'(rd_f)  >= NREG)) bad_enc = 1'b1;
    if (use_rs1 && (32'(rs1_f) >= NREG)) bad_enc = 1'b1;
    if (use_rs2 && (32'(rs2_f) >= NREG)) bad_enc = 1'b1;
  end

  assign invalid_c = bad_enc;
  assign rs1a_o    = AW'(rs1_f);
  assign rs2a_o    = AW'(rs2_f);
  assign rd_idx_c  = AW'(rd_f);
  assign rd_wr_c   = use_rd && (rd_idx_c != '0);

`ifdef ID_WB_FWD_EN
  assign fwd1_c     = wb_valid_i && (wb_rd_i == rs1a_o) && (cnt_q[rs1a_o] == CNT_W'(1));
  assign fwd2_c     = wb_valid_i && (wb_rd_i == rs2a_o) && (cnt_q[rs2a_o] == CNT_W'(1));
  assign rs1_data_c = fwd1_c ? wb_data_i : rs1d_i;
  assign rs2_data_c = fwd2_c ? wb_data_i : rs2d_i;
`else
  assign fwd1_c     = 1'b0;
  assign fwd2_c     = 1'b0;
  assign rs1_data_c = rs1d_i;
  assign rs2_data_c = rs2d_i;
`endif

  // Hazard check and issue decision; x0 is never tracked
  assign rs1_rdy_c = !use_rs1 || (rs1a_o == '0) || (cnt_q[rs1a_o] == '0) || fwd1_c;
  assign rs2_rdy_c = !use_rs2 || (rs2a_o == '0) || (cnt_q[rs2a_o] == '0) || fwd2_c;
  assign rd_ok_c   = !rd_wr_c || (cnt_q[rd_idx_c] != CNT_MAX);
  assign issue_c   = valid_i && (!valid_o || ack_i) && !flush_i && !halt_i && !invalid_c
                     && rs1_rdy_c && rs2_rdy_c && rd_ok_c && !rst_i;
  assign ack_o     = issue_c;
  assign illegal_o = valid_i && invalid_c && !rst_i;

  // A flushed, un-consumed instruction will never write back: release its rd
  assign fl_dec_c  = flush_i && valid_o && !ack_i && out_wr_q;

  // Counter update: increment on issue, decrement on writeback and flush release
  always_comb begin
    sb_err_d   = sb_err_o;
    sb_empty_d = 1'b1;
    avail      = '0;
    dec        = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      avail = {1'b0, cnt_q[r]} + (CNT_W+1)'(issue_c && rd_wr_c && (rd_idx_c == AW'(r)));
      dec   = (CNT_W+1)'(wb_valid_i && (wb_rd_i == AW'(r)))
            + (CNT_W+1)'(fl_dec_c && (out_rd_q == AW'(r)));
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (dec > avail) begin
        cnt_d[r] = '0;
        if (wb_valid_i && (wb_rd_i == AW'(r))) sb_err_d = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(avail - dec);
      end
      if (cnt_d[r] != '0) sb_empty_d = 1'b0;
    end
  end

  // Scoreboard state registers
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
      sb_err_o   <= 1'b0;
      sb_empty_o <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      sb_err_o   <= sb_err_d;
      sb_empty_o <= sb_empty_d;
    end
  end

  // Output register: flush kills, halt freezes, issue loads, bare ack drains
  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      instr_o  <= '0;
      pc_o     <= '0;
      rs1_o    <= '0;
      rs2_o    <= '0;
      imm_o    <= '0;
      out_rd_q <= '0;
      out_wr_q <= 1'b0;
    end else if (flush_i) begin
      valid_o  <= 1'b0;
    end else if (!halt_i) begin
      if (issue_c) begin
        valid_o  <= 1'b1;
        instr_o  <= instr_i;
        pc_o     <= pc_i;
        rs1_o    <= rs1_data_c;
        rs2_o    <= rs2_data_c;
        imm_o    <= imm_c;
        out_rd_q <= rd_idx_c;
        out_wr_q <= rd_wr_c;
      end else if (ack_i) begin
        valid_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_sb.sv
// tb_id_stage_sb: directed vector table plus hand-written hazard/flush/halt/error sequences.
module tb_id_stage_sb;

  localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADDI2 = 32'h00000113;  // addi x2,x0,0
  localparam logic [31:0] ADD3  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] BADI  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, halt_i, valid_i, ack_i, wb_valid_i;
  logic [31:0] instr_i, pc_i, rs1d_i, rs2d_i;
  logic [4:0]  rs1a_o, rs2a_o, wb_rd_i;
  logic        ack_o, valid_o, illegal_o, sb_empty_o, sb_err_o;
  logic [31:0] instr_o, pc_o, rs1_o, rs2_o, imm_o;
`ifdef ID_WB_FWD_EN
  logic [31:0] wb_data_i;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Regfile stand-in: data encodes the address so captured operands are predictable
  assign rs1d_i = 32'h100 + 32'(rs1a_o);
  assign rs2d_i = 32'h200 + 32'(rs2a_o);

  id_stage_sb #(.XLEN(32), .NREG(32), .CNT_W(1)) dut (
    .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .halt_i(halt_i),
    .rs1a_o(rs1a_o), .rs2a_o(rs2a_o), .rs1d_i(rs1d_i), .rs2d_i(rs2d_i),
    .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i), .ack_o(ack_o), .ack_i(ack_i),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .imm_o(imm_o), .illegal_o(illegal_o), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
`ifdef ID_WB_FWD_EN
    .wb_data_i(wb_data_i),
`endif
    .sb_empty_o(sb_empty_o), .sb_err_o(sb_err_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic        ack;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  vec_t vec [10];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    valid_i    = 1'b0;
    ack_i      = 1'b1;
    flush_i    = 1'b0;
    halt_i     = 1'b0;
    wb_valid_i = 1'b0;
    wb_rd_i    = '0;
    instr_i    = '0;
  endtask

  // Retire one writeback to rd and let the scoreboard settle
  task automatic retire(input logic [4:0] rd);
    valid_i    = 1'b0;
    wb_valid_i = 1'b1;
    wb_rd_i    = rd;
    tick;
    wb_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{32'h00500093, 1'b1, 32'h00000005, 5'd1};  // addi x1,x0,5
    vec[1] = '{32'hFFF00113, 1'b1, 32'hFFFFFFFF, 5'd2};  // addi x2,x0,-1
    vec[2] = '{32'h123452B7, 1'b1, 32'h12345000, 5'd5};  // lui x5,0x12345
    vec[3] = '{32'h00112423, 1'b1, 32'h00000008, 5'd0};  // sw x1,8(x2)
    vec[4] = '{32'hFE000EE3, 1'b1, 32'hFFFFFFFC, 5'd0};  // beq x0,x0,-4
    vec[5] = '{32'hFFFFFFFF, 1'b0, 32'h00000000, 5'd0};  // bad opcode
    vec[6] = '{32'h00003003, 1'b0, 32'h00000000, 5'd0};  // load funct3=3
    vec[7] = '{32'h40208033, 1'b1, 32'h00000000, 5'd0};  // sub x0,x1,x2
    vec[8] = '{32'h4020C033, 1'b0, 32'h00000000, 5'd0};  // funct7=0x20 with xor
    vec[9] = '{32'h010000EF, 1'b1, 32'h00000010, 5'd1};  // jal x1,16

    idle;
    pc_i  = 32'h0;
    rst_i = 1'b1;
`ifdef ID_WB_FWD_EN
    wb_data_i = 32'h0;
`endif

    // Reset with an instruction waiting
    valid_i = 1'b1;
    instr_i = ADDI1;
    tick;
    chk1("rst_ack0", ack_o, 1'b0);
    tick;
    chk1("rst_ack1", ack_o, 1'b0);
    chk1("rst_valid", valid_o, 1'b0);
    chk1("rst_empty", sb_empty_o, 1'b1);
    chk1("rst_err", sb_err_o, 1'b0);
    chk32("rst_instr", instr_o, 32'h0);
    rst_i = 1'b0;
    idle;
    tick;

    // Decode table: one instruction at a time from an empty scoreboard
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1;
      instr_i = vec[i].instr;
      pc_i    = 32'h1000 + 32'(i * 4);
      ack_i   = 1'b1;
      #3;
      chk1("vec_ack", ack_o, vec[i].ack);
      chk1("vec_illegal", illegal_o, !vec[i].ack);
      tick;
      chk1("vec_valid", valid_o, vec[i].ack);
      if (vec[i].ack) begin
        chk32("vec_instr", instr_o, vec[i].instr);
        chk32("vec_imm", imm_o, vec[i].imm);
        chk32("vec_pc", pc_o, 32'h1000 + 32'(i * 4));
        chk1("vec_busy", sb_empty_o, vec[i].rd == 5'd0);
      end
      retire(vec[i].rd);
      chk1("vec_drain", valid_o, 1'b0);
      chk1("vec_empty", sb_empty_o, 1'b1);
      chk1("vec_err", sb_err_o, 1'b0);
    end

    // RAW on x1
    idle;
    valid_i = 1'b1;
    instr_i = ADDI1;
    #3 chk1("raw_ack_producer", ack_o, 1'b1);
    tick;
    chk1("raw_valid", valid_o, 1'b1);
    chk1("raw_busy", sb_empty_o, 1'b0);
    instr_i = ADD3;
    #3 chk1("raw_stall", ack_o, 1'b0);
    tick;
    chk1("raw_drain", valid_o, 1'b0);
    #3 chk1("raw_stall2", ack_o, 1'b0);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd1;
`ifdef ID_WB_FWD_EN
    wb_data_i  = 32'd5;
    #3 chk1("raw_fwd_ack", ack_o, 1'b1);
    tick;
    wb_valid_i = 1'b0;
    valid_i    = 1'b0;
    chk1("raw_fwd_valid", valid_o, 1'b1);
    chk32("raw_fwd_rs1", rs1_o, 32'd5);
    chk32("raw_fwd_rs2", rs2_o, 32'h202);
`else
    #3 chk1("raw_wb_cycle", ack_o, 1'b0);
    tick;
    wb_valid_i = 1'b0;
    #3 chk1("raw_ack_after_wb", ack_o, 1'b1);
    tick;
    valid_i = 1'b0;
    chk1("raw_valid2", valid_o, 1'b1);
    chk32("raw_rs1", rs1_o, 32'h101);
    chk32("raw_rs2", rs2_o, 32'h202);
`endif
    chk32("raw_instr", instr_o, ADD3);
    retire(5'd3);
    chk1("raw_empty", sb_empty_o, 1'b1);

    // WAW at counter limit 1
    idle;
    tick;
    valid_i = 1'b1;
    instr_i = ADDI1;
    #3 chk1("waw_first", ack_o, 1'b1);
    tick;
    #3 chk1("waw_stall", ack_o, 1'b0);
    tick;
    chk1("waw_drain", valid_o, 1'b0);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd1;
    #3 chk1("waw_stall_wb", ack_o, 1'b0);
    tick;
    wb_valid_i = 1'b0;
    #3 chk1("waw_issue", ack_o, 1'b1);
    tick;
    valid_i = 1'b0;
    chk1("waw_valid", valid_o, 1'b1);
    chk1("waw_cnt1", sb_empty_o, 1'b0);
    retire(5'd1);
    chk1("waw_empty", sb_empty_o, 1'b1);

    // Flush releases the held instruction's rd
    idle;
    tick;
    valid_i = 1'b1;
    instr_i = ADDI1;
    tick;
    chk1("fl_held", valid_o, 1'b1);
    ack_i   = 1'b0;
    flush_i = 1'b1;
    instr_i = ADDI2;
    #3 chk1("fl_no_ack", ack_o, 1'b0);
    tick;
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk1("fl_valid", valid_o, 1'b0);
    chk1("fl_empty", sb_empty_o, 1'b1);
    chk1("fl_err", sb_err_o, 1'b0);

    // Halt freezes the output register while writeback proceeds
    idle;
    tick;
    valid_i = 1'b1;
    instr_i = ADDI1;
    tick;
    chk1("halt_pre", valid_o, 1'b1);
    halt_i     = 1'b1;
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd1;
    instr_i    = ADD3;
    #3 chk1("halt_no_ack", ack_o, 1'b0);
    tick;
    wb_valid_i = 1'b0;
    chk1("halt_frozen", valid_o, 1'b1);
    chk32("halt_instr", instr_o, ADDI1);
    chk1("halt_empty", sb_empty_o, 1'b1);
    #3 chk1("halt_no_ack2", ack_o, 1'b0);
    tick;
    chk1("halt_frozen2", valid_o, 1'b1);
    halt_i = 1'b0;
    #3 chk1("halt_release", ack_o, 1'b1);
    tick;
    valid_i = 1'b0;
    chk32("halt_add", instr_o, ADD3);
    chk32("halt_rs1", rs1_o, 32'h101);
    retire(5'd3);
    chk1("halt_done", sb_empty_o, 1'b1);

    // Sticky error, illegal stall, reset mid-stall
    idle;
    retire(5'd5);
    chk1("err_set", sb_err_o, 1'b1);
    chk1("err_empty", sb_empty_o, 1'b1);
    tick;
    chk1("err_sticky", sb_err_o, 1'b1);
    valid_i = 1'b1;
    instr_i = BADI;
    #3;
    chk1("ill_flag", illegal_o, 1'b1);
    chk1("ill_ack", ack_o, 1'b0);
    tick;
    chk1("ill_valid", valid_o, 1'b0);
    chk1("ill_still", illegal_o, 1'b1);
    instr_i = ADDI1;
    #3 chk1("mid_ack", ack_o, 1'b1);
    tick;
    chk1("mid_busy", sb_empty_o, 1'b0);
    instr_i = ADD3;
    rst_i   = 1'b1;
    #3;
    chk1("mid_rst_ack", ack_o, 1'b0);
    tick;
    rst_i = 1'b0;
    valid_i = 1'b0;
    chk1("mid_rst_valid", valid_o, 1'b0);
    chk1("mid_rst_empty", sb_empty_o, 1'b1);
    chk1("mid_rst_err", sb_err_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
